bus_rr_arbiter: RTL and testbench

- Round-robin bus arbiter for the 4-master shared bus.
- Sits upstream of the master mux, address decoder and slave mux chain.
- Takes active-low requests from masters 0-3 and drives one-hot active-low registered grants plus an owner index.
- Observes the returned m_rdy_n so a master that exceeds its hold limit is pre-empted only at a transfer boundary.

---
 rtl/bus_rr_arbiter_pkg.sv | 17 +
 rtl/bus_rr_pick.sv | 35 +++
 rtl/bus_rr_arbiter.sv | 88 ++++++++
 tb/tb_bus_rr_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus definitions for the round-robin arbiter: channel count, owner type
// and the active-low enable/disable levels used on request and grant lines.
`ifndef ENABLE_
`define ENABLE_ 1'b0
`endif
`ifndef DISABLE_
`define DISABLE_ 1'b1
`endif

package bus_rr_arbiter_pkg;

    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;

    typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin search: first active request after the current owner,
// excluding the owner itself. N must equal 2**W so the index wraps naturally.
module bus_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] owner,
    output logic [W-1:0] next_owner,
    output logic         found
);

    logic [W-1:0] cand_idx [1:N-1];
    logic [N-1:1] hit;

    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_cand
            assign cand_idx[gi] = owner + W'(gi);
            assign hit[gi]      = req[cand_idx[gi]];
        end
    endgenerate

    // Walk from the farthest candidate down so the nearest hit wins.
    always_comb begin
        found      = 1'b0;
        next_owner = owner;
        for (int k = N - 1; k >= 1; k--) begin
            if (hit[k]) begin
                found      = 1'b1;
                next_owner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the 4-master shared bus: owner register, hold counter
// with transfer-boundary pre-emption, and registered one-hot active-low grants.
import bus_rr_arbiter_pkg::*;

module bus_rr_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_n,
    input  logic       m1_req_n,
    input  logic       m2_req_n,
    input  logic       m3_req_n,
    input  logic       m_rdy_n,
    output logic       m0_grnt_n,
    output logic       m1_grnt_n,
    output logic       m2_grnt_n,
    output logic       m3_grnt_n,
    output logic [1:0] owner
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);

    logic [BUS_MASTER_CH-1:0] req;
    bus_owner_t               owner_reg, owner_next;
    bus_owner_t               pick_owner;
    logic                     pick_found;
    logic                     owner_req;
    logic [HOLD_W-1:0]        hold_cnt_reg, hold_cnt_next;
    logic [BUS_MASTER_CH-1:0] grnt_n_reg, grnt_n_next;

    assign req       = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};
    assign owner_req = req[owner_reg];

    bus_rr_pick #(
        .N(BUS_MASTER_CH),
        .W(BUS_OWNER_W)
    ) u_pick (
        .req        (req),
        .owner      (owner_reg),
        .next_owner (pick_owner),
        .found      (pick_found)
    );

    always_comb begin
        owner_next    = owner_reg;
        hold_cnt_next = hold_cnt_reg;
        if (!owner_req) begin
            // Release: hand over if anyone waits, otherwise park on this owner.
            if (pick_found) owner_next = pick_owner;
            hold_cnt_next = '0;
        end else if ((HOLD_MAX != 0) && (hold_cnt_reg == HOLD_LIMIT) &&
                     (m_rdy_n == `ENABLE_) && pick_found) begin
            owner_next    = pick_owner;
            hold_cnt_next = '0;
        end else if (pick_found) begin
            if (hold_cnt_reg != HOLD_LIMIT) hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end else begin
            hold_cnt_next = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < BUS_MASTER_CH; gi++) begin : g_grnt
            assign grnt_n_next[gi] = (owner_next == BUS_OWNER_W'(gi)) ? `ENABLE_ : `DISABLE_;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg    <= '0;
            hold_cnt_reg <= '0;
            grnt_n_reg   <= 4'b1110;
        end else begin
            owner_reg    <= owner_next;
            hold_cnt_reg <= hold_cnt_next;
            grnt_n_reg   <= grnt_n_next;
        end
    end

    assign owner     = owner_reg;
    assign m0_grnt_n = grnt_n_reg[0];
    assign m1_grnt_n = grnt_n_reg[1];
    assign m2_grnt_n = grnt_n_reg[2];
    assign m3_grnt_n = grnt_n_reg[3];

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter with HOLD_MAX=4: expected owner is queued
// as each cycle's stimulus is driven and compared after the following edge.
module tb_bus_rr_arbiter;

    logic       clk;
    logic       reset;
    logic       m0_req_n, m1_req_n, m2_req_n, m3_req_n;
    logic       m_rdy_n;
    logic       m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;
    logic [1:0] owner;

    int n_compared;
    int n_mismatched;

    typedef struct {
        string      tag;
        logic [1:0] owner;
    } exp_t;

    exp_t exp_q[$];

    bus_rr_arbiter #(
        .HOLD_MAX(4),
        .HOLD_W  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req_n  (m0_req_n),
        .m1_req_n  (m1_req_n),
        .m2_req_n  (m2_req_n),
        .m3_req_n  (m3_req_n),
        .m_rdy_n   (m_rdy_n),
        .m0_grnt_n (m0_grnt_n),
        .m1_grnt_n (m1_grnt_n),
        .m2_grnt_n (m2_grnt_n),
        .m3_grnt_n (m3_grnt_n),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected owner, check after the edge.
    task automatic cycle(input logic rst, input logic [3:0] rq_n, input logic rdy_n,
                         input logic [1:0] exp_owner, input string tag);
        exp_t       e;
        logic [3:0] exp_grnt;
        logic [3:0] obs_grnt;
        reset = rst;
        {m3_req_n, m2_req_n, m1_req_n, m0_req_n} = rq_n;
        m_rdy_n = rdy_n;
        e.tag   = tag;
        e.owner = exp_owner;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue"}, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            exp_grnt = ~(4'b0001 << e.owner);
            obs_grnt = {m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n};
            check_val({e.tag, "_owner"}, {6'd0, owner}, {6'd0, e.owner});
            check_val({e.tag, "_grnt"}, {4'd0, obs_grnt}, {4'd0, exp_grnt});
            $display("cycle %-12s req_n=%b rdy_n=%b rst=%b -> owner=%0d grnt_n=%b",
                     e.tag, rq_n, rdy_n, rst, owner, obs_grnt);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset    = 1'b1;
        m0_req_n = 1'b1; m1_req_n = 1'b1; m2_req_n = 1'b1; m3_req_n = 1'b1;
        m_rdy_n  = 1'b1;

        // Reset and idle parking on master 0
        cycle(1'b1, 4'b1111, 1'b1, 2'd0, "reset");
        cycle(1'b1, 4'b1111, 1'b1, 2'd0, "reset");
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'b1111, 1'b1, 2'd0, "idle");

        // Idle bus grant to m2 in one cycle, then park on m2
        cycle(1'b0, 4'b1011, 1'b0, 2'd2, "m2_grant");
        cycle(1'b0, 4'b1011, 1'b0, 2'd2, "m2_hold");
        cycle(1'b0, 4'b1111, 1'b1, 2'd2, "m2_park");
        cycle(1'b0, 4'b1111, 1'b1, 2'd2, "m2_park");

        // Round-robin handoffs 1 -> 2 -> 3 -> 0 (wrap)
        cycle(1'b0, 4'b1101, 1'b1, 2'd1, "m1_grant");
        cycle(1'b0, 4'b0010, 1'b1, 2'd2, "rr_1to2");
        cycle(1'b0, 4'b0110, 1'b1, 2'd3, "rr_2to3");
        cycle(1'b0, 4'b1110, 1'b1, 2'd0, "rr_3to0");
        cycle(1'b0, 4'b1111, 1'b1, 2'd0, "m0_park");

        // Pre-emption: 4 counted cycles, pre-empt on the 5th edge
        cycle(1'b0, 4'b1110, 1'b0, 2'd0, "m0_own");
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b1100, 1'b0, 2'd0, "hold_cnt");
        cycle(1'b0, 4'b1100, 1'b0, 2'd1, "preempt");
        cycle(1'b0, 4'b1111, 1'b0, 2'd1, "m1_park");

        // Saturated counter waits for a completion cycle
        cycle(1'b0, 4'b1110, 1'b1, 2'd0, "m0_own2");
        for (int i = 0; i < 12; i++) cycle(1'b0, 4'b1100, 1'b1, 2'd0, "sat_wait");
        cycle(1'b0, 4'b1100, 1'b0, 2'd1, "sat_preempt");

        // Reset mid-transfer with m3 owning and m0 requesting
        cycle(1'b0, 4'b0110, 1'b1, 2'd3, "m3_grant");
        cycle(1'b0, 4'b0110, 1'b1, 2'd3, "m3_xfer");
        cycle(1'b1, 4'b0110, 1'b1, 2'd0, "mid_reset");
        cycle(1'b0, 4'b0110, 1'b1, 2'd0, "post_reset");
        cycle(1'b0, 4'b1111, 1'b1, 2'd0, "final_park");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
